// File: rtl/mesh_pkt_pkg.sv
// Shared packet layout, drop codes and helpers for the mesh terminal source queue.
// Header occupies the top HDR_W bits of every packet; the payload fills the rest.
package mesh_pkt_pkg;

  localparam int NXT_JUMP_W = 8;
  localparam int ID_W       = 4;
  localparam int HDR_W      = NXT_JUMP_W + 2 * ID_W + 1;
  localparam int MODE_BIT   = 0;  // bit index of mode inside the header

  typedef enum logic [1:0] {
    DROP_NONE = 2'b00,
    DROP_FULL = 2'b01,
    DROP_BAD  = 2'b10,
    DROP_SELF = 2'b11
  } drop_e;

  // A terminal sits on the mesh rim: an edge column of an interior row, or vice versa.
  function automatic logic is_terminal(input logic [ID_W-1:0] row, input logic [ID_W-1:0] col,
                                       input int rows, input int colums);
    int r;
    int c;
    r = int'(row);
    c = int'(col);
    return ((r >= 32'sd1) && (r <= rows) && ((c == 32'sd0) || (c == colums + 32'sd1))) ||
           ((c >= 32'sd1) && (c <= colums) && ((r == 32'sd0) || (r == rows + 32'sd1)));
  endfunction

  function automatic logic [HDR_W-1:0] mk_pkt_hdr(input logic [ID_W-1:0] row,
                                                  input logic [ID_W-1:0] col,
                                                  input logic mode);
    logic [HDR_W-1:0] hdr;
    hdr           = {8'h00, row, col, 1'b0};
    hdr[MODE_BIT] = mode;
    return hdr;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Packet FIFO with modulo-depth pointers and an explicit occupancy counter.
// Pops while empty are ignored; flush clears everything and discards same-cycle traffic.
module sync_fifo #(
  parameter int PKT_W = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       wr_i,
  input  logic [PKT_W-1:0]           data_i,
  input  logic                       rd_i,
  output logic                       pndng_o,
  output logic [PKT_W-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_eff, pop_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pndng_o  = (cnt_q != '0);
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign count_o  = cnt_q;
  assign data_o   = pndng_o ? mem_q[rd_q] : '0;
  assign pop_eff  = rd_i & pndng_o & ~flush_i;
  assign push_eff = wr_i & ~flush_i & (~full_o | pop_eff);

  // Next-state pointers and occupancy.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_eff) wr_d = ptr_inc(wr_q);
      else          wr_d = wr_q;
      if (pop_eff)  rd_d = ptr_inc(rd_q);
      else          rd_d = rd_q;
      case ({push_eff, pop_eff})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: empty slots are never presented.
  always_ff @(posedge clk) begin
    if (!reset && push_eff) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mesh_term_src_queue.sv
// Terminal source stage: checks the destination, builds the mesh header, queues packets
// for the terminal handshake and reports/counts rejected pushes.
module mesh_term_src_queue
  import mesh_pkt_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int SRC_ROW    = 0,
  parameter int SRC_COL    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_i,
  input  logic [ID_W-1:0]                 dst_row_i,
  input  logic [ID_W-1:0]                 dst_col_i,
  input  logic                            mode_i,
  input  logic [pckg_sz-18:0]             payload_i,
  input  logic                            flush_i,
  output logic                            accept_o,
  output logic [1:0]                      drop_o,
  output logic                            pndng_i_in,
  output logic [pckg_sz-1:0]              data_out_i_in,
  input  logic                            popin,
  output logic [$clog2(fifo_depth+1)-1:0] count_o,
  output logic                            full_o,
  output logic [15:0]                     ovf_cnt_o,
  output logic [15:0]                     bad_addr_cnt_o
);

  logic               addr_ok, self_hit, pop_eff;
  logic [pckg_sz-1:0] pkt;
  drop_e              drop_q, drop_d;
  logic [15:0]        ovf_q, ovf_d, bad_q, bad_d;

  assign addr_ok  = is_terminal(dst_row_i, dst_col_i, ROWS, COLUMS);
  assign self_hit = (dst_row_i == ID_W'(SRC_ROW)) && (dst_col_i == ID_W'(SRC_COL));
  assign pop_eff  = popin & pndng_i_in;
  assign accept_o = push_i & ~reset & ~flush_i & addr_ok & ~self_hit & (~full_o | pop_eff);
  assign pkt      = {mk_pkt_hdr(dst_row_i, dst_col_i, mode_i), payload_i};

  sync_fifo #(
    .PKT_W (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .wr_i    (accept_o),
    .data_i  (pkt),
    .rd_i    (popin),
    .pndng_o (pndng_i_in),
    .data_o  (data_out_i_in),
    .count_o (count_o),
    .full_o  (full_o)
  );

  // Rejection reason (address before capacity) and saturating drop counters.
  always_comb begin
    drop_d = DROP_NONE;
    ovf_d  = ovf_q;
    bad_d  = bad_q;
    if (push_i && !flush_i) begin
      if (!addr_ok)                drop_d = DROP_BAD;
      else if (self_hit)           drop_d = DROP_SELF;
      else if (full_o && !pop_eff) drop_d = DROP_FULL;
      else                         drop_d = DROP_NONE;
    end else begin
      drop_d = DROP_NONE;
    end
    case (drop_d)
      DROP_FULL: begin
        if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
        else                   ovf_d = ovf_q;
      end
      DROP_BAD, DROP_SELF: begin
        if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
        else                   bad_d = bad_q;
      end
      default: begin
        ovf_d = ovf_q;
        bad_d = bad_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= DROP_NONE;
      ovf_q  <= 16'd0;
      bad_q  <= 16'd0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      bad_q  <= bad_d;
    end
  end

  assign drop_o         = drop_q;
  assign ovf_cnt_o      = ovf_q;
  assign bad_addr_cnt_o = bad_q;

endmodule
